// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: producer-side accept and consumer-side pop.
// The master modport is the side that offers immediates and consumes results.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_neg;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_neg
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_neg
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a 2-entry result buffer. Extension happens on accept,
// so the buffer holds finished results and the outputs come straight from the head entry.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input logic              clk,
  input logic              rst,
  imm_extend_pipe_if.slave p
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_r;
  occ_e             state_nxt_s;
  logic             accept_s;
  logic             pop_s;
  logic [OUT_W-1:0] ext_s;
  logic [OUT_W-1:0] head_data_r;
  logic [TAG_W-1:0] head_tag_r;
  logic [OUT_W-1:0] tail_data_r;
  logic [TAG_W-1:0] tail_tag_r;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    logic [OUT_W-1:0] sext;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend = sext;
      2'b01:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
      2'b11:   extend = sext << 2'd2;
      default: extend = sext;
    endcase
  endfunction

  // in_ready comes only from the state flop (and reset), never from out_ready
  assign p.in_ready  = (state_r != FULL) && !rst;
  assign p.out_valid = (state_r != EMPTY);
  assign p.out_data  = head_data_r;
  assign p.out_tag   = head_tag_r;
  assign p.out_neg   = head_data_r[OUT_W-1];

  assign accept_s = p.in_valid && p.in_ready;
  assign pop_s    = p.out_valid && p.out_ready;
  assign ext_s    = extend(p.in_imm, p.in_mode);

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Occupancy next-state: accept counts up, pop counts down, both cancel
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_nxt_s = ONE;
        else          state_nxt_s = EMPTY;
      end
      ONE: begin
        if (accept_s && !pop_s)      state_nxt_s = FULL;
        else if (!accept_s && pop_s) state_nxt_s = EMPTY;
        else                         state_nxt_s = ONE;
      end
      FULL: begin
        if (pop_s) state_nxt_s = ONE;
        else       state_nxt_s = FULL;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Entry storage: head is always slot 0; a pop from FULL shifts the tail forward
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_r <= {OUT_W{1'b0}};
      head_tag_r  <= {TAG_W{1'b0}};
      tail_data_r <= {OUT_W{1'b0}};
      tail_tag_r  <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            head_data_r <= ext_s;
            head_tag_r  <= p.in_tag;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            head_data_r <= ext_s;
            head_tag_r  <= p.in_tag;
          end else if (accept_s) begin
            tail_data_r <= ext_s;
            tail_tag_r  <= p.in_tag;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_data_r <= tail_data_r;
            head_tag_r  <= tail_tag_r;
          end
        end
        default: begin
          head_data_r <= {OUT_W{1'b0}};
          head_tag_r  <= {TAG_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe against a queue-based reference model.
module tb_imm_extend_pipe;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } item_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  item_t q[$];

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) p ();
  imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16), .TAG_W(5)) p8 ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (.clk(clk), .rst(rst), .p(p));
  imm_extend_pipe #(.IN_W(8),  .OUT_W(16), .TAG_W(5)) dut8 (.clk(clk), .rst(rst), .p(p8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference extension from arithmetic on the immediate's numeric value
  function automatic longint ref_ext(input longint imm, input int mode, input int in_w, input int out_w);
    longint mask;
    longint simm;
    mask = (64'sd1 <<< out_w) - 64'sd1;
    simm = imm;
    if (imm >= (64'sd1 <<< (in_w - 1))) simm = imm - (64'sd1 <<< in_w);
    case (mode)
      0:       return simm & mask;
      1:       return imm & mask;
      2:       return (imm * (64'sd1 <<< (out_w - in_w))) & mask;
      3:       return (simm * 64'sd4) & mask;
      default: return 64'sd0;
    endcase
  endfunction

  task automatic check_outputs();
    check_val("out_valid", {63'd0, p.out_valid}, {63'd0, q.size() != 0});
    check_val("in_ready", {63'd0, p.in_ready}, {63'd0, q.size() < 2});
    if (q.size() != 0) begin
      check_val("out_data", {32'd0, p.out_data}, {32'd0, q[0].data});
      check_val("out_tag", {59'd0, p.out_tag}, {59'd0, q[0].tag});
      check_val("out_neg", {63'd0, p.out_neg}, {63'd0, q[0].data[31]});
    end
  endtask

  // One clock: drive, predict accept/pop from the model, step, then compare
  task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag, input logic ordy);
    bit    acc;
    bit    pop;
    item_t it;
    p.in_valid  = v;
    p.in_imm    = imm;
    p.in_mode   = mode;
    p.in_tag    = tag;
    p.out_ready = ordy;
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() != 0);
    it.data = 32'(ref_ext(longint'(imm), int'(mode), 16, 32));
    it.tag  = tag;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(it);
    check_outputs();
  endtask

  task automatic directed(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
    cycle(1'b1, imm, mode, 5'd7, 1'b1);
    check_val("directed", {32'd0, p.out_data}, {32'd0, exp});
    cycle(1'b0, 16'd0, 2'd0, 5'd0, 1'b1);
  endtask

  task automatic sweep(input logic [7:0] imm, input logic [1:0] mode, input logic [15:0] exp);
    p8.in_valid  = 1'b1;
    p8.in_imm    = imm;
    p8.in_mode   = mode;
    p8.in_tag    = 5'd1;
    p8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    p8.in_valid = 1'b0;
    check_val("sweep", {48'd0, p8.out_data}, {48'd0, exp});
    check_val("sweep_model", {48'd0, p8.out_data}, 64'(ref_ext(longint'(imm), int'(mode), 8, 16)));
  endtask

  initial begin
    logic [31:0] r;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    p.in_valid = 1'b0; p.in_imm = 16'd0; p.in_mode = 2'd0; p.in_tag = 5'd0; p.out_ready = 1'b0;
    p8.in_valid = 1'b0; p8.in_imm = 8'd0; p8.in_mode = 2'd0; p8.in_tag = 5'd0; p8.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", {63'd0, p.out_valid}, 64'd0);
    check_val("rst_ready", {63'd0, p.in_ready}, 64'd0);
    check_val("rst_data", {32'd0, p.out_data}, 64'd0);
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", {63'd0, p.in_ready}, 64'd1);

    // Sign mode, then remaining modes with fixed expectations
    cycle(1'b1, 16'h8001, 2'b00, 5'd3, 1'b1);
    check_val("sign_data", {32'd0, p.out_data}, 64'hFFFF8001);
    check_val("sign_tag", {59'd0, p.out_tag}, 64'd3);
    check_val("sign_neg", {63'd0, p.out_neg}, 64'd1);
    cycle(1'b0, 16'd0, 2'd0, 5'd0, 1'b1);
    directed(16'h8001, 2'b01, 32'h00008001);
    directed(16'h1234, 2'b10, 32'h12340000);
    directed(16'hFFFF, 2'b11, 32'hFFFFFFFC);
    directed(16'h0004, 2'b11, 32'h00000010);

    // Back-pressure: A, B fill the buffer, C is refused
    cycle(1'b1, 16'h00AA, 2'b01, 5'd10, 1'b0);
    cycle(1'b1, 16'h00BB, 2'b01, 5'd11, 1'b0);
    check_val("bp_ready", {63'd0, p.in_ready}, 64'd0);
    cycle(1'b1, 16'h00CC, 2'b01, 5'd12, 1'b0);
    check_val("bp_hold", {32'd0, p.out_data}, 64'h000000AA);
    cycle(1'b0, 16'd0, 2'd0, 5'd0, 1'b1);
    check_val("bp_second", {32'd0, p.out_data}, 64'h000000BB);
    cycle(1'b0, 16'd0, 2'd0, 5'd0, 1'b1);
    check_val("bp_drained", {63'd0, p.out_valid}, 64'd0);

    // Streaming with distinct tags
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'(i * 300), 2'b00, 5'(i + 16), 1'b1);
      check_val("stream_ready", {63'd0, p.in_ready}, 64'd1);
      check_val("stream_tag", {59'd0, p.out_tag}, 64'(i + 16));
    end
    cycle(1'b0, 16'd0, 2'd0, 5'd0, 1'b1);

    // Reset between edges with a full buffer
    cycle(1'b1, 16'h1111, 2'b00, 5'd1, 1'b0);
    cycle(1'b1, 16'h2222, 2'b00, 5'd2, 1'b0);
    p.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_valid", {63'd0, p.out_valid}, 64'd0);
    check_val("midrst_ready", {63'd0, p.in_ready}, 64'd0);
    check_val("midrst_data", {32'd0, p.out_data}, 64'd0);
    check_val("midrst_tag", {59'd0, p.out_tag}, 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("release_ready", {63'd0, p.in_ready}, 64'd1);
    repeat (3) cycle(1'b0, 16'd0, 2'd0, 5'd0, 1'b1);

    // Parameter sweep on the narrow instance
    sweep(8'h80, 2'b00, 16'hFF80);
    sweep(8'h80, 2'b01, 16'h0080);
    sweep(8'h80, 2'b10, 16'h8000);
    sweep(8'h80, 2'b11, 16'hFE00);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      cycle(r[0] | r[1], r[31:16], r[3:2], r[8:4], r[9] | r[10]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
